serial_word_feeder: RTL and testbench

Parallel-in/serial-out stage that feeds the serial bit input of the Mealy "11" sequence detector. It accepts W-bit words over a valid/ready handshake and shifts them out MSB first, one bit per clock, with a qualifying valid strobe. Consecutive words stream with no gap between them. The line idles at 0 so the detector sees no spurious 1s between words.

---
 rtl/serial_feeder_pkg.sv | 20 ++
 rtl/word_parity.sv | 14 +
 rtl/serial_word_feeder.sv | 136 +++++++++++++
 tb/tb_serial_word_feeder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared types and sizing helpers for serial_word_feeder.
//   state_t  : feeder FSM states (IDLE, SHIFT)
//   calc_n   : bits per word on the line (data bits, plus one if parity is on)
//   calc_cw  : bit-counter width for a W-bit word
package serial_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int calc_n(input int w, input bit parity);
    return parity ? w + 1 : w;
  endfunction

  function automatic int calc_cw(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/word_parity.sv
// word_parity: even-parity bit of a W-bit word (XOR reduction), combinational.
// Ports:
//   word  input  W  word to reduce
//   par   output 1  XOR of all bits of word
module word_parity #(
  parameter int W = 8
) (
  input  logic [W-1:0] word,
  output logic         par
);

  assign par = ^word;

endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: parallel-in / serial-out stage feeding the serial input
// of the "11" sequence detector. Words arrive over a valid/ready handshake
// and leave MSB first, one bit per clock, with a sout_valid strobe. Words
// stream back to back with no gap; the line idles at 0.
// Build option: define PARITY_EN to append an even-parity bit to every word.
// Ports:
//   clk         input   1  rising-edge clock
//   rst         input   1  asynchronous, active-low reset
//   din         input   W  parallel word, sampled only on an accept
//   din_valid   input   1  upstream has a word on din
//   din_ready   output  1  stage can accept a word this cycle
//   sout        output  1  serial bit (registered)
//   sout_valid  output  1  sout carries a data/parity bit (registered)
//   busy        output  1  a word is being shifted
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy
);

`ifdef PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int N  = calc_n(W, PAR_EN);
  localparam int CW = calc_cw(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t         state, state_nx;
  logic [W-1:0]   shreg, shreg_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           sout_nx, sout_valid_nx;
  logic           accept, last;

`ifdef PARITY_EN
  localparam logic [CW-1:0] LAST_DATA = CW'(W - 1);
  logic par_q, par_nx, din_par;

  word_parity #(.W(W)) u_parity (
    .word (din),
    .par  (din_par)
  );
`endif

  assign last      = (cnt == LAST_BIT);
  assign din_ready = (state == IDLE) || ((state == SHIFT) && last);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
`ifdef PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      sout       <= sout_nx;
      sout_valid <= sout_valid_nx;
`ifdef PARITY_EN
      par_q      <= par_nx;
`endif
    end
  end

  // The MSB goes straight to sout on load, so shreg holds only the bits still
  // to come, left-aligned; its MSB is always the next bit to send.
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    cnt_nx        = cnt;
    sout_nx       = sout;
    sout_valid_nx = sout_valid;
`ifdef PARITY_EN
    par_nx        = par_q;
`endif

    if (accept) begin
      state_nx      = SHIFT;
      shreg_nx      = {din[W-2:0], 1'b0};
      cnt_nx        = '0;
      sout_nx       = din[W-1];
      sout_valid_nx = 1'b1;
`ifdef PARITY_EN
      par_nx        = din_par;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          sout_nx       = 1'b0;
          sout_valid_nx = 1'b0;
        end
        SHIFT: begin
          if (last) begin
            state_nx      = IDLE;
            shreg_nx      = '0;
            cnt_nx        = '0;
            sout_nx       = 1'b0;
            sout_valid_nx = 1'b0;
          end else begin
            cnt_nx        = cnt + CW'(1);
            sout_nx       = shreg[W-1];
            shreg_nx      = {shreg[W-2:0], 1'b0};
            sout_valid_nx = 1'b1;
`ifdef PARITY_EN
            if (cnt == LAST_DATA) sout_nx = par_q;
`endif
          end
        end
        default: begin
          state_nx      = IDLE;
          sout_nx       = 1'b0;
          sout_valid_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
module tb_serial_word_feeder;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, sout, sout_valid, busy;

  serial_word_feeder #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One entry per expected valid bit; 'last' marks the cycle in which
  // din_ready must be high while a word is on the line.
  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sout_valid === 1'b1) begin
        check("bit_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("sout", 32'(sout), 32'(e.b));
          check("din_ready_in_word", 32'(din_ready), 32'(e.last));
          check("busy_in_word", 32'(busy), 32'd1);
        end
      end else begin
        check("sout_valid_idle", 32'(sout_valid), 32'd0);
        check("sout_idle", 32'(sout), 32'd0);
        check("din_ready_idle", 32'(din_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("no_pending_bits", 32'(q.size()), 32'd0);
      end
    end
  end

  // Present a word and wait (bounded) for it to be accepted; on return the
  // time is just after the accepting edge. hold keeps din_valid asserted so
  // the caller can present the next word back to back.
  task automatic send(input logic [W-1:0] w, input bit hold);
    bit acc;
    acc = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = (din_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      din_valid = 1'b0;
      return;
    end
    for (int i = W - 1; i >= 0; i--)
      q.push_back('{b: w[i], last: (!PAR && i == 0)});
    if (PAR) q.push_back('{b: ^w, last: 1'b1});
    if (!hold) begin
      din_valid = 1'b0;
      din = ~w;  // later din changes must not affect the word in flight
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset then idle
    repeat (10) @(posedge clk);
    #1;

    // Single word: 1,0,1,1,0,1,1,0
    send(8'hB6, 1'b0);
    repeat (12) @(posedge clk);
    #1;

    // Back to back: FF then 03, valid held high
    send(8'hFF, 1'b1);
    send(8'h03, 1'b0);
    repeat (14) @(posedge clk);
    #1;

    // Stall: second word presented mid-word, waits for the last bit cycle
    send(8'hC3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(8'h5A, 1'b0);
    repeat (14) @(posedge clk);
    #1;

    // Reset mid-word during bit 3 of F0
    send(8'hF0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    check("rst_sout_valid", 32'(sout_valid), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Recovery after reset
    send(8'h96, 1'b0);
    repeat (12) @(posedge clk);
    #1;

    // Parity words (plain data words in the default build)
    send(8'h07, 1'b1);
    send(8'h03, 1'b0);

    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
